// File: rtl/target_checker.sv
// target_checker: judges SHA-256d digests against a held 256-bit target, one slice per cycle, MSB slice first
module target_checker #(
    parameter int SLICE_W = 32,
    parameter int COUNT_W = 32
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               target_load_i,
    input  logic [255:0]       full_target_i,
    input  logic               hash_valid_i,
    output logic               hash_ready_o,
    input  logic [255:0]       hash_i,
    input  logic [31:0]        nonce_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic               res_hit_o,
    output logic [31:0]        res_nonce_o,
    output logic               busy_o,
    input  logic               clear_counts_i,
    output logic [COUNT_W-1:0] hashes_o,
    output logic [COUNT_W-1:0] hits_o
);
    localparam int N  = 256 / SLICE_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [255:0]       hv_q, hv_d, snap_q, snap_d, target_q, target_d, hv_in;
    logic [31:0]        nonce_q, nonce_d;
    logic               hit_q, hit_d;
    logic [COUNT_W-1:0] hashes_q, hashes_d, hits_q, hits_d;
    logic [SLICE_W-1:0] hs, ts;
    logic               accept, decide, dec_hit;

    // Digest bytes arrive in wire order; reverse them to get the little-endian numeric value.
    for (genvar k = 0; k < 32; k++) begin : g_rev
        assign hv_in[8*k +: 8] = hash_i[255-8*k -: 8];
    end

    assign hs           = hv_q[idx_q*SLICE_W +: SLICE_W];
    assign ts           = snap_q[idx_q*SLICE_W +: SLICE_W];
    assign hash_ready_o = (state_q == IDLE) & ~target_load_i;
    assign accept       = hash_valid_i & hash_ready_o;
    assign res_valid_o  = state_q == DONE;
    assign busy_o       = state_q != IDLE;
    assign res_hit_o    = hit_q;
    assign res_nonce_o  = nonce_q;
    assign hashes_o     = hashes_q;
    assign hits_o       = hits_q;

    // Next-state: capture on accept, walk slices MSB-first with early exit, counters bump on the decision.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hv_d     = hv_q;
        snap_d   = snap_q;
        nonce_d  = nonce_q;
        hit_d    = hit_q;
        target_d = target_load_i ? full_target_i : target_q;
        decide   = 1'b0;
        dec_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CMP;
                    idx_d   = IW'(N - 1);
                    hv_d    = hv_in;
                    snap_d  = target_q;
                    nonce_d = nonce_i;
                end
            end
            CMP: begin
                if (hs != ts || idx_q == '0) begin
                    decide  = 1'b1;
                    dec_hit = hs <= ts;
                    hit_d   = dec_hit;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: state_d = res_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        hashes_d = clear_counts_i ? '0 : decide ? hashes_q + COUNT_W'(1) : hashes_q;
        hits_d   = clear_counts_i ? '0 : (decide & dec_hit) ? hits_q + COUNT_W'(1) : hits_q;
    end

    // State registers; reset aborts any compare in flight and drops its result.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            idx_q    <= IW'(N - 1);
            hv_q     <= '0;
            snap_q   <= '0;
            target_q <= '0;
            nonce_q  <= '0;
            hit_q    <= 1'b0;
            hashes_q <= '0;
            hits_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hv_q     <= hv_d;
            snap_q   <= snap_d;
            target_q <= target_d;
            nonce_q  <= nonce_d;
            hit_q    <= hit_d;
            hashes_q <= hashes_d;
            hits_q   <= hits_d;
        end
    end
endmodule
